// File: rtl/sample_buffer_controller.sv
// Ping-pong capture sequencer: fills two sample buffers alternately and streams full ones to the host.
// Optional macro TEST_PATTERN_EN builds the internal ramp counter selected by testMode.
module sample_buffer_controller #(
  parameter int BUFFER_AW = 8
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        collectData,
  input  logic        testMode,
  input  logic [9:0]  adcData,
  input  logic        readData,
  output logic        dataAvailable,
  output logic [15:0] dataOut,
  output logic        bufferOverflow
);

  localparam int MEM_WORDS = 2 ** (BUFFER_AW + 1);

  typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_WAIT} wr_state_e;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_e;

  wr_state_e            wr_state_q, wr_state_d;
  rd_state_e            rd_state_q, rd_state_d;
  logic                 wr_buf_q, wr_buf_d;
  logic                 rd_buf_q, rd_buf_d;
  logic [BUFFER_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUFFER_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]           full_q, full_d;
  logic                 last_done_q, last_done_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          dout_q, dout_d;
  logic                 collect_q, collect_d;

  logic                 collect_rise;
  logic                 wr_done;
  logic                 wr_other;
  logic                 wr_blocked;
  logic                 rd_strobe;
  logic                 rd_free;
  logic                 mem_we;
  logic [9:0]           sample;
  logic [9:0]           rd_word;
  logic [9:0]           mem [MEM_WORDS];

`ifdef TEST_PATTERN_EN
  logic [9:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (collect_rise) begin
      cnt_d = 10'd0;
    end else if (collectData && wr_state_q == WR_FILL) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      cnt_q <= 10'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample = testMode ? cnt_q : adcData;
`else
  logic unused_test_mode;
  assign unused_test_mode = testMode;
  assign sample = adcData;
`endif

  assign collect_d    = collectData;
  assign collect_rise = collectData & ~collect_q;
  assign wr_done      = collectData && (wr_state_q == WR_FILL) && (wr_ptr_q == '1);
  assign rd_strobe    = collectData && (rd_state_q == RD_ACTIVE) && readData;
  assign rd_free      = rd_strobe && (rd_ptr_q == '1);
  assign wr_other     = ~wr_buf_q;
  // A buffer released by the reader on this same edge counts as empty.
  assign wr_blocked   = full_q[wr_other] && !(rd_free && (rd_buf_q == wr_other));
  assign rd_word      = mem[{rd_buf_q, rd_ptr_q}];

  always_comb begin
    wr_state_d = wr_state_q;
    wr_buf_d   = wr_buf_q;
    wr_ptr_d   = wr_ptr_q;
    mem_we     = 1'b0;
    if (!collectData) begin
      wr_state_d = WR_IDLE;
      wr_buf_d   = 1'b0;
      wr_ptr_d   = '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          wr_state_d = WR_FILL;
          wr_buf_d   = 1'b0;
          wr_ptr_d   = '0;
        end
        WR_FILL: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + BUFFER_AW'(1);
          if (wr_done) begin
            wr_buf_d = wr_other;
            wr_ptr_d = '0;
            if (wr_blocked) begin
              wr_state_d = WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (!full_q[wr_buf_q]) begin
            wr_state_d = WR_FILL;
            wr_ptr_d   = '0;
          end
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_buf_d   = rd_buf_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    if (!collectData) begin
      rd_state_d = RD_IDLE;
      rd_buf_d   = 1'b0;
      rd_ptr_d   = '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (full_q != 2'b00 || wr_done) begin
            rd_state_d = RD_ACTIVE;
            rd_ptr_d   = '0;
            if (full_q == 2'b11) begin
              rd_buf_d = ~last_done_q;
            end else if (full_q[0]) begin
              rd_buf_d = 1'b0;
            end else if (full_q[1]) begin
              rd_buf_d = 1'b1;
            end else begin
              rd_buf_d = wr_buf_q;
            end
          end
        end
        RD_ACTIVE: begin
          if (rd_strobe) begin
            rd_ptr_d = rd_ptr_q + BUFFER_AW'(1);
            dout_d   = {~rd_word[9], rd_word[8:0], 6'b000000};
            if (rd_free) begin
              rd_state_d = RD_IDLE;
            end
          end
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  always_comb begin
    full_d      = full_q;
    last_done_d = last_done_q;
    ovf_d       = ovf_q;
    if (rd_free) begin
      full_d[rd_buf_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_buf_q] = 1'b1;
      last_done_d      = wr_buf_q;
    end
    if (!collectData) begin
      full_d      = 2'b00;
      last_done_d = 1'b0;
    end
    if (collect_rise) begin
      ovf_d = 1'b0;
    end else if (wr_done && wr_blocked) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    dataAvailable  = (rd_state_q == RD_ACTIVE);
    dataOut        = dout_q;
    bufferOverflow = ovf_q;
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      wr_state_q  <= WR_IDLE;
      rd_state_q  <= RD_IDLE;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 2'b00;
      last_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      dout_q      <= 16'h0000;
      collect_q   <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      last_done_q <= last_done_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      collect_q   <= collect_d;
    end
  end

  always_ff @(posedge inclk) begin
    if (mem_we) begin
      mem[{wr_buf_q, wr_ptr_q}] <= sample;
    end
  end

endmodule

// File: tb/tb_sample_buffer_controller.sv
// Directed bench for sample_buffer_controller with 16-word buffers.
// Without TEST_PATTERN_EN the bench drives adcData with the ramp the internal counter would produce.
module tb_sample_buffer_controller;

  logic        inclk = 1'b0;
  logic        reset;
  logic        collectData;
  logic        testMode;
  logic [9:0]  adcData;
  logic        readData;
  logic        dataAvailable;
  logic [15:0] dataOut;
  logic        bufferOverflow;

  int testsRun = 0;
  int testsFailed = 0;
  logic rampOn = 1'b0;
  int rampVal = 0;

  sample_buffer_controller #(.BUFFER_AW(4)) dut (
    .inclk          (inclk),
    .reset          (reset),
    .collectData    (collectData),
    .testMode       (testMode),
    .adcData        (adcData),
    .readData       (readData),
    .dataAvailable  (dataAvailable),
    .dataOut        (dataOut),
    .bufferOverflow (bufferOverflow)
  );

  always #5 inclk = ~inclk;

  // Advance one edge, then present the next ramp sample for the following edge.
  task automatic tick();
    @(posedge inclk);
    #1;
    if (rampOn) begin
`ifdef TEST_PATTERN_EN
      adcData = 10'h2AA;
`else
      adcData = rampVal[9:0];
`endif
      rampVal++;
    end
  endtask

  task automatic applyStimulus(input logic collect, input logic rd, input int cycles);
    collectData = collect;
    readData    = rd;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {15'd0, observed}, {15'd0, expected});
  endtask

  task automatic startCapture(input logic mode);
    testMode = mode;
    rampOn   = mode;
    rampVal  = 0;
    applyStimulus(1'b1, 1'b0, 1);
  endtask

  task automatic stopCapture();
    rampOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  task automatic readWords(input string tag, input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput(tag, dataOut, first + 16'(i * 64));
    end
    readData = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    collectData = 1'b0;
    testMode    = 1'b0;
    adcData     = 10'd0;
    readData    = 1'b0;
    tick();
    tick();
    checkFlag("rst_avail", dataAvailable, 1'b0);
    checkOutput("rst_dout", dataOut, 16'h0000);
    checkFlag("rst_ovf", bufferOverflow, 1'b0);
    reset = 1'b0;
    tick();

    // Continuous host reads: buffer 0 drains as buffer 1 completes, writer keeps going.
    startCapture(1'b1);
    applyStimulus(1'b1, 1'b0, 15);
    checkFlag("s1_avail_early", dataAvailable, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkFlag("s1_avail_rise", dataAvailable, 1'b1);
    readWords("s1_buf0", 16, 16'h8000);
    checkFlag("s1_avail_fall", dataAvailable, 1'b0);
    checkFlag("s1_ovf", bufferOverflow, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkFlag("s1_avail_buf1", dataAvailable, 1'b1);
    readWords("s1_buf1", 16, 16'h8400);
    applyStimulus(1'b1, 1'b0, 1);
    readWords("s1_buf0_nogap", 16, 16'h8800);
    stopCapture();
    checkFlag("s1_stop_avail", dataAvailable, 1'b0);

    // No reads: both buffers fill, overflow follows sample 32, oldest buffer is offered first.
    startCapture(1'b1);
    applyStimulus(1'b1, 1'b0, 31);
    checkFlag("s2_ovf_before", bufferOverflow, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkFlag("s2_ovf_set", bufferOverflow, 1'b1);
    readWords("s2_buf0", 16, 16'h8000);
    checkFlag("s2_gap", dataAvailable, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkFlag("s2_avail_buf1", dataAvailable, 1'b1);
    readWords("s2_buf1", 16, 16'h8400);
    stopCapture();
    checkFlag("s2_ovf_sticky", bufferOverflow, 1'b1);

    // ADC source: mid-scale and full-scale conversion.
    adcData = 10'd512;
    startCapture(1'b0);
    checkFlag("s3_ovf_clear", bufferOverflow, 1'b0);
    applyStimulus(1'b1, 1'b0, 16);
    readWords("s3_adc512", 1, 16'h0000);
    stopCapture();
    adcData = 10'd1023;
    startCapture(1'b0);
    applyStimulus(1'b1, 1'b0, 16);
    readWords("s3_adc1023", 1, 16'h7FC0);
    stopCapture();

    // Asynchronous reset in the middle of a capture.
    startCapture(1'b1);
    applyStimulus(1'b1, 1'b0, 16);
    readWords("s4_pre", 2, 16'h8000);
    #2;
    reset = 1'b1;
    #1;
    checkFlag("s4_async_avail", dataAvailable, 1'b0);
    checkOutput("s4_async_dout", dataOut, 16'h0000);
    checkFlag("s4_async_ovf", bufferOverflow, 1'b0);
    rampOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1);
    reset = 1'b0;
    tick();
    startCapture(1'b1);
    applyStimulus(1'b1, 1'b0, 16);
    readWords("s4_first", 1, 16'h8000);
    stopCapture();

    // Capture dropped mid-read, strobes ignored, restart clears overflow and counter.
    startCapture(1'b1);
    applyStimulus(1'b1, 1'b0, 32);
    checkFlag("s5_ovf_set", bufferOverflow, 1'b1);
    readWords("s5_partial", 5, 16'h8000);
    stopCapture();
    checkFlag("s5_avail_drop", dataAvailable, 1'b0);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("s5_dout_hold", dataOut, 16'h8100);
    startCapture(1'b1);
    checkFlag("s5_ovf_clear", bufferOverflow, 1'b0);
    applyStimulus(1'b1, 1'b0, 16);
    readWords("s5_restart", 1, 16'h8000);
    stopCapture();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sample_buffer_controller.md
Name: sample_buffer_controller

Overview:
- Ping-pong capture sequencer between the 10-bit sample source (ADC bus or internal test counter) and the USB read side.
- Fills two on-chip buffers alternately at one sample per inclk.
- Flags a full buffer to the host with dataAvailable, then streams it out as 16-bit signed words on readData strobes.
- Detects and reports overrun when the host falls behind.

Parameters:
- BUFFER_AW, 8: buffer address width; each buffer holds 2^BUFFER_AW words; total storage 2*2^BUFFER_AW x 10 bits.

Ports:
- inclk  input  1  sample/system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- collectData  input  1  capture enable from host; level
- testMode  input  1  1 = source is internal counter, 0 = adcData
- adcData  input  10  unsigned ADC sample, sampled every inclk edge
- readData  input  1  host read strobe; one word per cycle high
- dataAvailable  output  1  a full buffer is being offered to host
- dataOut  output  16  signed sample word
- bufferOverflow  output  1  sticky overrun flag

Behaviour:
- Reset (async, active-high) values: dataAvailable=0, dataOut=16'h0000, bufferOverflow=0. Both buffers empty, writer IDLE, reader IDLE, test counter=0, all pointers=0.
- Conversion: dataOut = {sample[9]^1, sample[8:0], 6'b000000}, i.e. (sample-512)<<6. 0 -> 16'h8000, 512 -> 16'h0000, 1023 -> 16'h7FC0.
- Test counter: 10-bit, +1 every cycle in FILL, wraps 1023 -> 0, cleared to 0 on collectData rising edge.
- Writer FSM states: IDLE, FILL, WAIT.
  - IDLE -> FILL on collectData=1; starts at buffer 0, word 0.
  - FILL: writes one sample per cycle. After word 2^BUFFER_AW-1, that buffer is marked full at the same edge. Next cycle writer moves to the other buffer at word 0 if it is empty; otherwise goes to WAIT and sets bufferOverflow.
  - WAIT: samples dropped, test counter holds. Leaves to FILL (word 0 of the freed buffer) the cycle after the reader frees it.
  - Same-cycle completion and free: evaluated on post-free state. Writer switches directly and no overflow is flagged.
- Reader FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE when any buffer is full; oldest-filled buffer first. dataAvailable goes 1 on entry to ACTIVE.
  - ACTIVE: each cycle with readData=1 presents the next word. dataOut is valid 1 cycle after the edge sampling readData (word 0 after the first strobe). Read pointer advances by 1.
  - After the strobe for the last word: buffer freed, dataAvailable=0 next cycle, reader -> IDLE.
  - dataAvailable stays low at least 1 cycle between consecutive buffers.
  - readData while dataAvailable=0: ignored; dataOut holds.
  - Gaps in readData: pointer and dataOut hold.
- collectData falling (any state): next edge returns writer and reader to IDLE, marks both buffers empty, clears pointers and dataAvailable. Partial and unread data are discarded; dataOut holds its last value.
- bufferOverflow: sticky. Cleared only by reset or collectData rising edge.
- testMode is sampled continuously; changing it mid-capture switches source at the next sample (no realignment).

Optional Feature:
- TEST_PATTERN_EN
  - Defined: test counter is built and testMode selects the source as above.
  - Undefined: counter is not built, testMode is ignored, and adcData is always the source.

Test Plan:
- BUFFER_AW=4, TEST_PATTERN_EN defined, testMode=1, raise collectData, host strobes readData continuously once dataAvailable=1 -> dataAvailable rises after 16 samples. dataOut sequence is 16'h8000, 16'h8040, ... 16'h83C0. dataAvailable falls 1 cycle after the 16th strobe; bufferOverflow stays 0.
- Same setup, no reads -> buffer 0 full at sample 16, buffer 1 full at sample 32. bufferOverflow=1 the cycle after sample 32. After reading all 16 words of buffer 0, the next buffer offered is buffer 1 (words 16..31 -> 16'h8400..16'h87C0).
- testMode=0, adcData held at 512 then 1023 -> dataOut 16'h0000 then 16'h7FC0.
- Reset asserted mid-FILL with dataAvailable=1 -> all outputs 0 immediately (async). After release and collectData high, first word read is test value 0 (16'h8000).
- collectData dropped mid-read of buffer 0 (after 5 strobes) -> dataAvailable=0 next edge and further readData is ignored. Re-raise collectData -> bufferOverflow=0 and the counter restarts at 0.
- Reader frees buffer 1 on the same edge that the writer completes buffer 0 while in FILL -> writer continues into buffer 1 with no gap and bufferOverflow stays 0.
